// File: rtl/ppu_mem_pkg.sv
// ppu_mem_pkg: shared geometry defaults, clog2 helper and clear FSM states
package ppu_mem_pkg;
   localparam int DEF_WORD_W = 8;
   localparam int DEF_SLICE_W = 2;
   localparam int DEF_DEPTH = 32;
   typedef enum logic {CLEAR, READY} clear_state_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/ppu_subword_ram_if.sv
// ppu_subword_ram_if: word port A, slice port B and clear control of the sub-word RAM
interface ppu_subword_ram_if import ppu_mem_pkg::*; #(
   parameter int WORD_W = DEF_WORD_W,
   parameter int SLICE_W = DEF_SLICE_W,
   parameter int DEPTH = DEF_DEPTH
) ();
   localparam int SLICES = WORD_W / SLICE_W;
   localparam int AW_A = clog2(DEPTH);
   localparam int AW_B = AW_A + clog2(SLICES);
   logic clear_req;
   logic busy;
   logic [AW_A-1:0] address_a;
   logic [WORD_W-1:0] data_a;
   logic wren_a;
   logic [SLICES-1:0] mask_a;
   logic [WORD_W-1:0] q_a;
   logic [AW_B-1:0] address_b;
   logic [SLICE_W-1:0] data_b;
   logic wren_b;
   logic [SLICE_W-1:0] q_b;
   modport master (
      output clear_req, address_a, data_a, wren_a, mask_a, address_b, data_b, wren_b,
      input busy, q_a, q_b
   );
   modport slave (
      input clear_req, address_a, data_a, wren_a, mask_a, address_b, data_b, wren_b,
      output busy, q_a, q_b
   );
endinterface

// File: rtl/ppu_slice_bank.sv
// ppu_slice_bank: DEPTH x W dual-port read-first RAM; port A has a split write
// address so the clear sweep can write while port A keeps reading its own address
module ppu_slice_bank import ppu_mem_pkg::*; #(
   parameter int W = DEF_SLICE_W,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW = clog2(DEPTH)
) (
   input  logic clock,
   input  logic reset,
   input  logic we_a,
   input  logic [AW-1:0] wr_addr_a,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [W-1:0] wd_a,
   output logic [W-1:0] q_a,
   input  logic we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [W-1:0] wd_b,
   output logic [W-1:0] q_b
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clock) begin
      if (we_a) mem[wr_addr_a] <= wd_a;
      if (we_b) mem[addr_b] <= wd_b;
      q_a <= reset ? '0 : mem[rd_addr_a];
      q_b <= reset ? '0 : mem[addr_b];
   end
endmodule

// File: rtl/ppu_subword_ram.sv
// ppu_subword_ram: word-view port A / slice-view port B over SLICES banks,
// with B-over-A write arbitration and a self-clearing init sweep
module ppu_subword_ram import ppu_mem_pkg::*; #(
   parameter int WORD_W = DEF_WORD_W,
   parameter int SLICE_W = DEF_SLICE_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
   input logic clock,
   input logic reset,
   ppu_subword_ram_if.slave bus
);
   localparam int SLICES = WORD_W / SLICE_W;
   localparam int AW_A = clog2(DEPTH);
   localparam int SW = clog2(SLICES);
   clear_state_t state, state_n;
   logic [AW_A-1:0] cnt, cnt_n, word_b;
   logic [SW-1:0] sel_b, sel_q;
   logic busy;
   logic [SLICES-1:0][SLICE_W-1:0] q_a_w;
   logic [SLICE_W-1:0] q_b_w [SLICES];
   assign busy = state == CLEAR;
   assign {word_b, sel_b} = bus.address_b;
   assign bus.busy = busy;
   assign bus.q_a = q_a_w;
   assign bus.q_b = q_b_w[sel_q];
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
         cnt <= '0;
         sel_q <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         sel_q <= sel_b;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      if (state == CLEAR) begin
         cnt_n = clear_req_restart() ? '0 : cnt + 1'b1;
         state_n = (!bus.clear_req && cnt == AW_A'(DEPTH - 1)) ? READY : CLEAR;
      end else if (bus.clear_req) begin
         state_n = CLEAR;
         cnt_n = '0;
      end
   end
   function automatic logic clear_req_restart();
      return bus.clear_req;
   endfunction
   for (genvar i = 0; i < SLICES; i++) begin : g_bank
      logic hit_b;
      assign hit_b = bus.wren_b && sel_b == SW'(i);
      // B owns a slice both ports write this cycle; the clear sweep overrides both
      ppu_slice_bank #(.W(SLICE_W), .DEPTH(DEPTH)) u_bank (
         .clock,
         .reset,
         .we_a(busy || (bus.wren_a && bus.mask_a[i] && !(hit_b && word_b == bus.address_a))),
         .wr_addr_a(busy ? cnt : bus.address_a),
         .rd_addr_a(bus.address_a),
         .wd_a(busy ? INIT_VAL[i*SLICE_W +: SLICE_W] : bus.data_a[i*SLICE_W +: SLICE_W]),
         .q_a(q_a_w[i]),
         .we_b(!busy && hit_b),
         .addr_b(word_b),
         .wd_b(bus.data_b),
         .q_b(q_b_w[i])
      );
   end
endmodule

// File: tb/tb_ppu_subword_ram.sv
// tb_ppu_subword_ram: directed checks of ppu_subword_ram with INIT_VAL 0x00 and 0xAA instances
module tb_ppu_subword_ram;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 clock = ~clock;
   ppu_subword_ram_if if0 ();
   ppu_subword_ram_if if1 ();
   ppu_subword_ram u_dut0 (.clock(clock), .reset(reset), .bus(if0));
   ppu_subword_ram #(.INIT_VAL(8'hAA)) u_dut1 (.clock(clock), .reset(reset), .bus(if1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic measure_busy(input string tag, input bit dut1);
      int n;
      n = 1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (!(dut1 ? if1.busy : if0.busy)) break;
         n++;
      end
      check(tag, 32'(n), 32'd32);
   endtask
   initial begin
      {if0.clear_req, if0.wren_a, if0.wren_b, if0.address_a, if0.address_b} = '0;
      {if0.data_a, if0.data_b, if0.mask_a} = '0;
      {if1.clear_req, if1.wren_a, if1.wren_b, if1.address_a, if1.address_b} = '0;
      {if1.data_a, if1.data_b, if1.mask_a} = '0;
      tick();
      check("rst_qa", 32'(if0.q_a), 32'h0);
      check("rst_qb", 32'(if0.q_b), 32'h0);
      check("rst_busy0", 32'(if0.busy), 32'h1);
      check("rst_busy1", 32'(if1.busy), 32'h1);
      reset = 1'b0;
      measure_busy("t1_busy_len", 1'b0);
      check("t1_busy1_low", 32'(if1.busy), 32'h0);
      for (int b = 0; b < 128; b++) begin
         if0.address_a = 5'(b >> 2);
         if0.address_b = 7'(b);
         if1.address_a = 5'(b >> 2);
         if1.address_b = 7'(b);
         tick();
         check("t1_qa0", 32'(if0.q_a), 32'h00);
         check("t1_qb0", 32'(if0.q_b), 32'h0);
         check("t1_qa1", 32'(if1.q_a), 32'hAA);
         check("t1_qb1", 32'(if1.q_b), 32'h2);
      end
      if0.address_a = 5'd5;
      if0.data_a = 8'hE4;
      if0.mask_a = 4'hF;
      if0.wren_a = 1'b1;
      tick();
      if0.wren_a = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if0.address_b = 7'(20 + s);
         tick();
         check("t2_qb_slice", 32'(if0.q_b), 32'(s));
      end
      check("t2_qa_word5", 32'(if0.q_a), 32'hE4);
      if0.address_b = 7'd22;
      if0.data_b = 2'b11;
      if0.wren_b = 1'b1;
      tick();
      check("t3_qa_cross_old", 32'(if0.q_a), 32'hE4);
      check("t3_qb_same_old", 32'(if0.q_b), 32'h2);
      if0.wren_b = 1'b0;
      tick();
      check("t3_qa_new", 32'(if0.q_a), 32'hF4);
      check("t3_qb_new", 32'(if0.q_b), 32'h3);
      if0.data_a = 8'h00;
      if0.wren_a = 1'b1;
      if0.address_b = 7'd21;
      if0.data_b = 2'b10;
      if0.wren_b = 1'b1;
      tick();
      check("t4_qa_same_old", 32'(if0.q_a), 32'hF4);
      if0.wren_a = 1'b0;
      if0.wren_b = 1'b0;
      tick();
      check("t4_collision", 32'(if0.q_a), 32'h08);
      if0.address_a = 5'd7;
      if0.data_a = 8'hFF;
      if0.mask_a = 4'b0101;
      if0.wren_a = 1'b1;
      tick();
      if0.wren_a = 1'b0;
      tick();
      check("t5_mask", 32'(if0.q_a), 32'h33);
      if0.address_b = 7'd28;
      tick();
      check("t5_qb28", 32'(if0.q_b), 32'h3);
      if0.address_b = 7'd29;
      tick();
      check("t5_qb29", 32'(if0.q_b), 32'h0);
      if0.address_b = 7'd30;
      tick();
      check("t5_qb30", 32'(if0.q_b), 32'h3);
      if1.address_a = 5'd3;
      if1.data_a = 8'h55;
      if1.mask_a = 4'hF;
      if1.wren_a = 1'b1;
      tick();
      if1.wren_a = 1'b0;
      tick();
      check("t6_pre_word3", 32'(if1.q_a), 32'h55);
      if1.clear_req = 1'b1;
      tick();
      if1.clear_req = 1'b0;
      check("t6_busy_start", 32'(if1.busy), 32'h1);
      tick();
      check("t6_read_while_busy", 32'(if1.q_a), 32'h55);
      if1.wren_a = 1'b1;
      if1.address_b = 7'd13;
      if1.data_b = 2'b01;
      if1.wren_b = 1'b1;
      repeat (9) tick();
      if1.clear_req = 1'b1;
      tick();
      if1.clear_req = 1'b0;
      check("t6_busy_restart", 32'(if1.busy), 32'h1);
      measure_busy("t6_busy_len", 1'b1);
      if1.wren_a = 1'b0;
      if1.wren_b = 1'b0;
      for (int w = 0; w < 32; w++) begin
         if1.address_a = 5'(w);
         if1.address_b = 7'(w * 4 + 1);
         tick();
         check("t6_qa_init", 32'(if1.q_a), 32'hAA);
         check("t6_qb_init", 32'(if1.q_b), 32'h2);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ppu_subword_ram.md
# ppu_subword_ram

Parametrised dual-view on-chip RAM for PPU sprite-attribute style tables. Port A is the CPU/DMA side and sees whole words. Port B is the renderer side and sees individual SLICE_W-bit slices of the same storage. It generalises the fixed 32x8 / 2-bit high-OAM store with configurable geometry, slice write masks on port A, defined cross-port collision rules, and a self-clearing init engine so the table starts from a known value after reset or on request.

## Interface
- WORD_W, 8, port A word width; must be a multiple of SLICE_W
- SLICE_W, 2, port B slice width
- DEPTH, 32, number of words; power of two, at least 2
- INIT_VAL, 0, WORD_W-bit value written to every word by the clear engine
- Derived: SLICES = WORD_W/SLICE_W; AW_A = clog2(DEPTH); AW_B = AW_A + clog2(SLICES)

Ports:
- clock, in, 1, single clock; all logic is posedge
- reset, in, 1, synchronous, active-high
- clear_req, in, 1, one-cycle pulse that starts a full clear to INIT_VAL
- busy, out, 1, high while the clear engine runs
- address_a, in, AW_A, word address
- data_a, in, WORD_W, write data
- wren_a, in, 1, word write strobe
- mask_a, in, SLICES, per-slice write enable; bit i covers data_a[i*SLICE_W +: SLICE_W]
- q_a, out, WORD_W, registered read data
- address_b, in, AW_B, slice address: {word, slice index}; slice 0 is the least-significant slice
- data_b, in, SLICE_W, write data
- wren_b, in, 1, slice write strobe
- q_b, out, SLICE_W, registered read data

## Operation
- Storage is SLICES independent banks, each DEPTH x SLICE_W. Word w, slice s is held in bank s, entry w.
- Port A reads all banks at address_a every cycle. A write updates bank i only when wren_a && mask_a[i].
- Port B reads bank address_b[low] at entry address_b[high]. A write updates that bank only.
- Read-during-write on the same port is read-first: the q output shows the old contents, and the new value is visible on the next read.
- Cross-port read-during-write is also read-first. A read on one port in the same cycle as a write to the same slice on the other port returns the old data.
- Write-write collision: if A and B write the same slice in the same cycle, port B wins for that slice. A's other masked slices still commit.
- Clear FSM has two states, CLEAR and READY.
  - reset forces CLEAR with cnt=0.
  - clear_req in READY moves to CLEAR with cnt=0.
  - In CLEAR, INIT_VAL is written to all banks at entry cnt and cnt increments. At cnt==DEPTH-1 the FSM goes to READY.
  - clear_req during CLEAR restarts the sweep at cnt=0.
- While busy:
  - wren_a and wren_b are ignored (dropped, not queued).
  - Reads still execute, and q outputs return whatever is stored at that moment.
- Reset values:
  - q_a=0 and q_b=0.
  - busy=1 and the state is CLEAR (the FSM enters CLEAR on reset).
  - cnt=0.
  - Memory contents are undefined until the sweep completes.

## Timing
- Read latency is 1 cycle. The address sampled at edge N appears on q at edge N+1 and holds until the next edge.
- The port B slice select is registered alongside the bank read so the output mux matches the returned data.
- Clear duration:
  - With reset high at edge R and low after it, edges R+1 .. R+DEPTH perform the writes, and busy is low from edge R+DEPTH.
  - The same DEPTH-cycle sweep applies from a clear_req edge.
- Reset asserted mid-sweep restarts at cnt=0. reset and clear_req together behave as reset.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package ppu_mem_pkg holds the clog2 helper, the default geometry constants (32x8, SLICE_W=2), and the FSM state enum {CLEAR, READY}.
- Sub-module ppu_slice_bank is a simple true-dual-port DEPTH x SLICE_W read-first RAM. It is instantiated SLICES times with a generate loop, and each instance maps to a block or distributed RAM primitive.
- The top level holds the clear FSM, the write-enable arbitration (B-over-A, busy gating, clear override), and the port B output mux.

## Test plan
1. Reset for 1 cycle, then release. busy stays 1 for exactly 32 cycles. Afterwards reading every word on A returns 0x00, and reading every slice on B returns 0.
2. A writes 0xE4 to word 5 with mask 4'b1111. B then reads addresses 20..23 and gets 0, 1, 2, 3. A reads word 5 and gets 0xE4.
3. B writes 2'b11 to address 22 (word 5, slice 2) while A reads word 5 in the same cycle. That read returns 0xE4, and the next A read returns 0xF4.
4. In the same cycle, A writes 0x00 with mask 4'b1111 to word 5 and B writes 2'b10 to address 21. The result is 0x08: B wins slice 1 and the other slices become 0.
5. A writes 0xFF with mask 4'b0101 to a zeroed word 7. A read of word 7 returns 0x33.
6. Trigger a clear with INIT_VAL=0xAA. Pulse clear_req again at cnt=10 and attempt writes while busy. busy lasts 32 cycles from the second pulse, the writes are dropped, and all words read 0xAA.
